// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: memory access sizes and data-memory responder states.
`default_nettype none

package cpu_defs;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

  // True when the access cannot be served as a naturally aligned transfer.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = addr_lo[0];
      MEM_WORD: is_misaligned = (addr_lo != 2'b00);
      default:  is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane_steer.sv
// dmem_lane_steer: byte-lane mask, replicated store data and extended load data.
`default_nettype none

module dmem_lane_steer
  import cpu_defs::*;
(
  input  mem_size_t   i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  input  logic        i_unsigned,
  output logic [3:0]  o_mask,
  output logic [31:0] o_wword,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[8*i_addr_lo +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  // Store data is replicated across lanes so the mask alone selects placement.
  always_comb begin
    o_mask  = 4'b1111;
    o_wword = i_wdata;
    o_ldata = i_rword;
    case (i_size)
      MEM_BYTE: begin
        o_mask  = 4'b0001 << i_addr_lo;
        o_wword = {4{i_wdata[7:0]}};
        o_ldata = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      MEM_HALF: begin
        o_mask  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wword = {2{i_wdata[15:0]}};
        o_ldata = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        o_mask  = 4'b1111;
        o_wword = i_wdata;
        o_ldata = i_rword;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave with wait states and valid/ready response.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
`default_nettype none

module dmem_responder
  import cpu_defs::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_wait_init = 4'(WAIT_STATES);

  dmem_state_t   r_state;
  logic [3:0]    r_cnt;
  logic          r_req_ready;
  logic          r_write;
  logic [AW+1:0] r_addr;
  mem_size_t     r_size;
  logic          r_unsigned;
  logic [31:0]   r_wdata;
  logic          r_err;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [3:0]    w_mask;
  logic [31:0]   w_wword;
  logic [31:0]   w_ldata;
  logic          w_req_err;
  logic          w_accept;
  logic          w_unused_addr;

  // Upper address bits are dropped so accesses wrap around the RAM.
  assign w_unused_addr = &{1'b0, req_addr[31:AW+2]};
  assign w_idx         = r_addr[AW+1:2];
  assign w_rword       = r_mem[w_idx];
  assign w_accept      = req_valid && r_req_ready;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_req_err = is_misaligned(mem_size_t'(req_size), req_addr[1:0]);
`else
  assign w_req_err = 1'b0;
`endif

  dmem_lane_steer u_steer (
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .i_unsigned (r_unsigned),
    .o_mask     (w_mask),
    .o_wword    (w_wword),
    .o_ldata    (w_ldata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_size      <= MEM_BYTE;
      r_unsigned  <= 1'b0;
      r_wdata     <= 32'd0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_write     <= req_write;
            r_addr      <= req_addr[AW+1:0];
            r_size      <= mem_size_t'(req_size);
            r_unsigned  <= req_unsigned;
            r_wdata     <= req_wdata;
            r_err       <= w_req_err;
            r_cnt       <= c_wait_init;
            r_state     <= (WAIT_STATES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= r_err;
          r_rsp_rdata <= (r_write || r_err) ? 32'd0 : w_ldata;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM contents survive reset; an abort before ACCESS leaves the state in IDLE, so no write.
  always_ff @(posedge clock) begin
    if (r_state == ACCESS && r_write && !r_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire
